// File: rtl/vc_egress_arbiter_pkg.sv
// rtl/vc_egress_arbiter_pkg.sv - shared constants and types for the VC egress arbiter
package vc_egress_arbiter_pkg;

    localparam int NUM_VC         = 4;
    localparam int DATA_WIDTH_DEF = 12;
    localparam int CNT_WIDTH_DEF  = 5;

    typedef logic [1:0] vc_idx_t;

endpackage

// File: rtl/vc_egress_arbiter_rr_pick.sv
// rtl/vc_egress_arbiter_rr_pick.sv - rotate-priority selector over the VC eligibility mask
module vc_egress_arbiter_rr_pick
    import vc_egress_arbiter_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible,
    input  vc_idx_t           rr_ptr,
    output logic              grant_valid,
    output vc_idx_t           grant_idx
);

    vc_idx_t cand;

    // Scan from the farthest offset down so the closest eligible VC to rr_ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            cand = rr_ptr + vc_idx_t'(i);
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vc_egress_arbiter.sv
// rtl/vc_egress_arbiter.sv - three-stage round-robin drain of four VC FIFOs into one egress FIFO
module vc_egress_arbiter
    import vc_egress_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    input  logic                  almost_full_out,
    output logic                  push_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]  count_0,
    output logic [CNT_WIDTH-1:0]  count_1,
    output logic [CNT_WIDTH-1:0]  count_2,
    output logic [CNT_WIDTH-1:0]  count_3,
    output logic                  idle
);

    logic [NUM_VC-1:0]    empty_vec;
    logic [NUM_VC-1:0]    pop_vec;
    logic [NUM_VC-1:0]    eligible;
    vc_idx_t              rr_ptr;
    vc_idx_t              sel_d;
    vc_idx_t              pop_idx;
    vc_idx_t              grant_idx;
    logic                 grant_valid;
    logic                 valid_d;
    logic [DATA_WIDTH-1:0] data_mux;
    logic [CNT_WIDTH-1:0] count [NUM_VC];

    assign empty_vec = {empty_3, empty_2, empty_1, empty_0};
    // A VC popped last cycle is held out: its empty flag has not caught up yet.
    assign eligible  = ~empty_vec & ~pop_vec;

    assign pop_0   = pop_vec[0];
    assign pop_1   = pop_vec[1];
    assign pop_2   = pop_vec[2];
    assign pop_3   = pop_vec[3];
    assign count_0 = count[0];
    assign count_1 = count[1];
    assign count_2 = count[2];
    assign count_3 = count[3];

    vc_egress_arbiter_rr_pick u_rr_pick (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Encode the one-hot pop vector so stage 2 can remember which VC was read.
    always_comb begin
        pop_idx = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pop_vec[i]) begin
                pop_idx = vc_idx_t'(i);
            end
        end
    end

    // Route the read data of the VC captured in stage 2.
    always_comb begin
        case (sel_d)
            2'd0:    data_mux = data_in_0;
            2'd1:    data_mux = data_in_1;
            2'd2:    data_mux = data_in_2;
            default: data_mux = data_in_3;
        endcase
    end

    // Stage 1: issue at most one pop per cycle and advance the round-robin pointer past the winner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_vec <= '0;
            rr_ptr  <= '0;
        end else begin
            pop_vec <= '0;
            if (!almost_full_out && grant_valid) begin
                pop_vec[grant_idx] <= 1'b1;
                rr_ptr             <= vc_idx_t'(grant_idx + 2'd1);
            end
        end
    end

    // Stage 2: remember which VC is delivering data in the current cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_d <= 1'b0;
            sel_d   <= '0;
        end else begin
            valid_d <= |pop_vec;
            if (|pop_vec) begin
                sel_d <= pop_idx;
            end
        end
    end

    // Stage 3: write the captured word to the egress FIFO and credit its source VC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push_out <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < NUM_VC; i++) begin
                count[i] <= '0;
            end
        end else begin
            push_out <= valid_d;
            if (valid_d) begin
                data_out     <= data_mux;
                count[sel_d] <= count[sel_d] + 1'b1;
            end
        end
    end

    assign idle = !reset ||
                  ((pop_vec == '0) && !valid_d && !push_out &&
                   ((&empty_vec) || almost_full_out));

endmodule

// File: tb/tb_vc_egress_arbiter.sv
// tb/tb_vc_egress_arbiter.sv - randomized self-checking bench against a queue-based reference model
module tb_vc_egress_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        almost_full_out;
    logic        emp [4];
    logic [11:0] din [4];
    logic        pop_0, pop_1, pop_2, pop_3;
    logic        push_out;
    logic [11:0] data_out;
    logic [4:0]  count_0, count_1, count_2, count_3;
    logic        idle;

    typedef struct {
        int          due;
        int          vc;
        logic [11:0] data;
    } infl_t;

    logic [11:0] fq [4][$];
    infl_t       infl [$];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_pop;
    int          m_rr;
    logic        m_push;
    logic [11:0] m_data;
    int          m_cnt [4];

    always #5 clk = ~clk;

    vc_egress_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .empty_0         (emp[0]),
        .empty_1         (emp[1]),
        .empty_2         (emp[2]),
        .empty_3         (emp[3]),
        .data_in_0       (din[0]),
        .data_in_1       (din[1]),
        .data_in_2       (din[2]),
        .data_in_3       (din[3]),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .pop_2           (pop_2),
        .pop_3           (pop_3),
        .almost_full_out (almost_full_out),
        .push_out        (push_out),
        .data_out        (data_out),
        .count_0         (count_0),
        .count_1         (count_1),
        .count_2         (count_2),
        .count_3         (count_3),
        .idle            (idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: decide next cycle's pop/push from the rules, using word queues.
    task automatic model_next();
        int g;
        if (!reset) begin
            m_pop = -1; m_rr = 0; m_push = 1'b0; m_data = '0;
            for (int v = 0; v < 4; v++) m_cnt[v] = 0;
            infl.delete();
        end else begin
            m_push = 1'b0;
            if (infl.size() > 0 && infl[0].due == cyc + 1) begin
                m_push = 1'b1;
                m_data = infl[0].data;
                m_cnt[infl[0].vc] = (m_cnt[infl[0].vc] + 1) % 32;
                void'(infl.pop_front());
            end
            g = -1;
            if (!almost_full_out) begin
                for (int i = 0; i < 4; i++) begin
                    int v;
                    v = (m_rr + i) % 4;
                    if (g < 0 && fq[v].size() > 0 && v != m_pop) g = v;
                end
            end
            if (g >= 0) begin
                infl_t e;
                e.due = cyc + 3; e.vc = g; e.data = fq[g][0];
                infl.push_back(e);
                m_rr = (g + 1) % 4;
            end
            m_pop = g;
        end
    endtask

    task automatic step();
        logic [3:0] dpop;
        logic [3:0] epop;
        logic       all_empty;
        logic       e_idle;
        for (int v = 0; v < 4; v++) emp[v] = (fq[v].size() == 0);
        model_next();
        @(negedge clk);
        cyc++;
        dpop = {pop_3, pop_2, pop_1, pop_0};
        epop = (m_pop >= 0) ? 4'(1 << m_pop) : 4'b0;
        all_empty = emp[0] && emp[1] && emp[2] && emp[3];
        e_idle = !reset || (m_pop < 0 && infl.size() == 0 && !m_push &&
                            (all_empty || almost_full_out));
        check("pop", 32'(dpop), 32'(epop));
        check("push_out", 32'(push_out), 32'(m_push));
        check("data_out", 32'(data_out), 32'(m_data));
        check("count_0", 32'(count_0), 32'(m_cnt[0]));
        check("count_1", 32'(count_1), 32'(m_cnt[1]));
        check("count_2", 32'(count_2), 32'(m_cnt[2]));
        check("count_3", 32'(count_3), 32'(m_cnt[3]));
        check("idle", 32'(idle), 32'(e_idle));
        for (int v = 0; v < 4; v++) begin
            if (dpop[v] && fq[v].size() > 0) din[v] = fq[v].pop_front();
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        steps(n);
        reset = 1'b1;
    endtask

    initial begin
        int seen;
        reset = 1'b0;
        almost_full_out = 1'b0;
        m_pop = -1; m_rr = 0; m_push = 1'b0; m_data = '0;
        for (int v = 0; v < 4; v++) begin
            m_cnt[v] = 0;
            din[v] = '0;
            emp[v] = 1'b1;
        end

        // Reset held with all VCs loaded, then one word per VC drained in order.
        for (int v = 0; v < 4; v++) fq[v].push_back(12'(12'h100 + v));
        steps(3);
        reset = 1'b1;
        steps(10);

        // Single VC: one word every two cycles.
        fq[2].push_back(12'h00A);
        fq[2].push_back(12'h00B);
        fq[2].push_back(12'h00C);
        steps(10);

        // Back-pressure raised the cycle after the VC1 pop.
        do_reset(1);
        fq[1].push_back(12'h111);
        fq[1].push_back(12'h112);
        fq[2].push_back(12'h222);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            step();
            if (pop_1) seen = 1;
        end
        check("vc1_pop_seen", 32'(seen), 32'd1);
        almost_full_out = 1'b1;
        steps(5);
        almost_full_out = 1'b0;
        steps(8);

        // Counter wrap on VC3: 32 pushes return count_3 to zero.
        do_reset(1);
        for (int i = 0; i < 32; i++) fq[3].push_back(12'($urandom));
        steps(70);
        check("count_3_wrap", 32'(count_3), 32'd0);

        // Reset while pop_1 is high and valid_d holds the VC0 word.
        do_reset(1);
        fq[0].push_back(12'h0F0);
        fq[1].push_back(12'h0F1);
        fq[2].push_back(12'h0F2);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            step();
            if (pop_1) seen = 1;
        end
        check("vc1_pop_before_reset", 32'(seen), 32'd1);
        do_reset(2);
        steps(8);

        // Randomized traffic, back-pressure and occasional reset.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int v;
                v = $urandom_range(0, 3);
                if (fq[v].size() < 8) fq[v].push_back(12'($urandom));
            end
            if ($urandom_range(0, 11) == 0) almost_full_out = ~almost_full_out;
            if ($urandom_range(0, 399) == 0) reset = 1'b0;
            else reset = 1'b1;
            step();
        end
        reset = 1'b1;
        almost_full_out = 1'b0;
        steps(40);
        check("final_idle", 32'(idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
